// File: rtl/vga_sync.sv
// Raster timing generator: pixel-rate enable, horizontal/vertical scan counters and sync decodes.
// Define VGA_SYNC_OUTREG_EN to register hsync/vsync/video_on on each pixel tick (one-pixel lag).
module vga_sync #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 4
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       frame_tick
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_LO  = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] H_SYNC_HI  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_LO  = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] V_SYNC_HI  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam logic [9:0] H_VIS      = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS      = 10'(V_DISPLAY);

    logic [DIV_W-1:0] div;
    logic [9:0]       h;
    logic [9:0]       v;
    logic             h_end;
    logic             v_end;
    logic             hsync_d;
    logic             vsync_d;
    logic             video_on_d;

    assign p_tick = (div == DIV_LAST);
    assign h_end  = (h == H_LAST);
    assign v_end  = (v == V_LAST);

    // NOTE: reset is tested first so it overrides any tick or wrap in the same cycle;
    // all state updates use non-blocking assignments so every counter sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            div <= '0;
            h   <= '0;
            v   <= '0;
        end else begin
            div <= p_tick ? '0 : div + DIV_W'(1);
            if (p_tick) begin
                h <= h_end ? '0 : h + 10'd1;
                if (h_end) begin
                    v <= v_end ? '0 : v + 10'd1;
                end
            end
        end
    end

    assign x          = h;
    assign y          = v;
    assign frame_tick = p_tick && h_end && v_end;

    assign hsync_d    = !((h >= H_SYNC_LO) && (h <= H_SYNC_HI));
    assign vsync_d    = !((v >= V_SYNC_LO) && (v <= V_SYNC_HI));
    assign video_on_d = (h < H_VIS) && (v < V_VIS);

`ifdef VGA_SYNC_OUTREG_EN
    logic hsync_q;
    logic vsync_q;
    logic video_on_q;

    // Loaded once per pixel, so these trail x/y by exactly one pixel period.
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            video_on_q <= 1'b0;
        end else if (p_tick) begin
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            video_on_q <= video_on_d;
        end
    end

    assign hsync    = hsync_q;
    assign vsync    = vsync_q;
    assign video_on = video_on_q;
`else
    assign hsync    = hsync_d;
    assign vsync    = vsync_d;
    assign video_on = video_on_d;
`endif

endmodule

// File: tb/tb_vga_sync.sv
// Self-checking bench for vga_sync: a shrunken-raster instance under random resets and a
// default 640x480 instance for line-level timing, both compared every cycle to an arithmetic model.
module tb_vga_sync;

    // Small raster so whole frames fit in a short run.
    localparam int S_HD = 16, S_HF = 2, S_HS = 3, S_HB = 2;
    localparam int S_VD = 8,  S_VF = 2, S_VS = 2, S_VB = 3;
    localparam int S_CD = 4;
    localparam int S_FRAME = (S_HD + S_HF + S_HS + S_HB) * (S_VD + S_VF + S_VS + S_VB) * S_CD;

    localparam int D_HD = 640, D_HF = 16, D_HS = 96, D_HB = 48;
    localparam int D_VD = 480, D_VF = 10, D_VS = 2,  D_VB = 33;
    localparam int D_CD = 4;

`ifdef VGA_SYNC_OUTREG_EN
    localparam int HS_FALL_X = 657;
    localparam int VON_FALL_X = 641;
`else
    localparam int HS_FALL_X = 656;
    localparam int VON_FALL_X = 640;
`endif

    typedef struct {
        int p_tick;
        int x;
        int y;
        int hsync;
        int vsync;
        int video_on;
        int frame_tick;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_s, rst_d;
    logic       p_tick_s, hsync_s, vsync_s, video_on_s, frame_tick_s;
    logic       p_tick_d, hsync_d, vsync_d, video_on_d, frame_tick_d;
    logic [9:0] x_s, y_s, x_d, y_d;

    int  checks = 0;
    int  errors = 0;
    int  t_s = 0, t_d = 0;
    bit  valid_s = 1'b0, valid_d = 1'b0;

    always #5 clk = ~clk;

    vga_sync #(
        .H_DISPLAY(S_HD), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
        .V_DISPLAY(S_VD), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
        .CLK_DIV(S_CD)
    ) dut_s (
        .clk(clk), .reset(rst_s), .p_tick(p_tick_s), .x(x_s), .y(y_s),
        .hsync(hsync_s), .vsync(vsync_s), .video_on(video_on_s), .frame_tick(frame_tick_s)
    );

    vga_sync dut_d (
        .clk(clk), .reset(rst_d), .p_tick(p_tick_d), .x(x_d), .y(y_d),
        .hsync(hsync_d), .vsync(vsync_d), .video_on(video_on_d), .frame_tick(frame_tick_d)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Outputs for the cycle t clocks after the last reset edge, from raster arithmetic alone.
    function automatic exp_t model(input int t, input int hd, input int hf, input int hs, input int hb,
                                   input int vd, input int vf, input int vs, input int vb, input int cd);
        exp_t e;
        int ht, vt, p, h, v, dh, dv;
        ht = hd + hf + hs + hb;
        vt = vd + vf + vs + vb;
        p  = t / cd;
        h  = p % ht;
        v  = (p / ht) % vt;
        e.p_tick     = ((t % cd) == cd - 1) ? 1 : 0;
        e.x          = h;
        e.y          = v;
        e.frame_tick = (e.p_tick == 1 && h == ht - 1 && v == vt - 1) ? 1 : 0;
`ifdef VGA_SYNC_OUTREG_EN
        if (p == 0) begin
            e.hsync = 1; e.vsync = 1; e.video_on = 0;
            return e;
        end
        dh = (p - 1) % ht;
        dv = ((p - 1) / ht) % vt;
`else
        dh = h;
        dv = v;
`endif
        e.hsync    = (dh >= hd + hf && dh < hd + hf + hs) ? 0 : 1;
        e.vsync    = (dv >= vd + vf && dv < vd + vf + vs) ? 0 : 1;
        e.video_on = (dh < hd && dv < vd) ? 1 : 0;
        return e;
    endfunction

    always @(posedge clk) begin
        if (rst_s === 1'b1) begin t_s <= 0; valid_s <= 1'b1; end
        else t_s <= t_s + 1;
        if (rst_d === 1'b1) begin t_d <= 0; valid_d <= 1'b1; end
        else t_d <= t_d + 1;
    end

    always @(negedge clk) begin
        exp_t es, ed;
        if (valid_s) begin
            es = model(t_s, S_HD, S_HF, S_HS, S_HB, S_VD, S_VF, S_VS, S_VB, S_CD);
            check("s_p_tick", 32'(p_tick_s), es.p_tick);
            check("s_x", 32'(x_s), es.x);
            check("s_y", 32'(y_s), es.y);
            check("s_hsync", 32'(hsync_s), es.hsync);
            check("s_vsync", 32'(vsync_s), es.vsync);
            check("s_video_on", 32'(video_on_s), es.video_on);
            check("s_frame_tick", 32'(frame_tick_s), es.frame_tick);
        end
        if (valid_d) begin
            ed = model(t_d, D_HD, D_HF, D_HS, D_HB, D_VD, D_VF, D_VS, D_VB, D_CD);
            check("d_p_tick", 32'(p_tick_d), ed.p_tick);
            check("d_x", 32'(x_d), ed.x);
            check("d_y", 32'(y_d), ed.y);
            check("d_hsync", 32'(hsync_d), ed.hsync);
            check("d_vsync", 32'(vsync_d), ed.vsync);
            check("d_video_on", 32'(video_on_d), ed.video_on);
            check("d_frame_tick", 32'(frame_tick_d), ed.frame_tick);
        end
    end

    initial begin
        int n, nt, hs_low, hs_x, von_x, ft_cnt;
        bit prev_von, found;

        rst_s = 1'b1;
        rst_d = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_x", 32'(x_d), 0);
        check("rst_y", 32'(y_d), 0);
        check("rst_hsync", 32'(hsync_d), 1);
        check("rst_vsync", 32'(vsync_d), 1);
        check("rst_p_tick", 32'(p_tick_d), 0);
        rst_s = 1'b0;
        rst_d = 1'b0;

        // First pixel tick CLK_DIV-1 clocks after release, then every CLK_DIV clocks.
        n = 0;
        while (!p_tick_d && n < 20) begin @(negedge clk); n++; end
        check("first_p_tick_delay", n, D_CD - 1);
        n = 0;
        @(negedge clk);
        while (!p_tick_d && n < 20) begin @(negedge clk); n++; end
        check("p_tick_spacing", n + 1, D_CD);

        // One full default line: hsync low-pixel count and fall positions.
        nt = 0; hs_low = 0; hs_x = -1; von_x = -1; n = 0;
        prev_von = video_on_d;
        while (nt < 800 && n < 4000) begin
            if (prev_von && !video_on_d && von_x < 0) von_x = int'(x_d);
            prev_von = video_on_d;
            if (p_tick_d) begin
                nt++;
                if (!hsync_d) begin
                    hs_low++;
                    if (hs_x < 0) hs_x = int'(x_d);
                end
            end
            @(negedge clk);
            n++;
        end
        check("line_ticks_seen", nt, 800);
        check("hsync_low_pixels", hs_low, 96);
        check("hsync_fall_x", hs_x, HS_FALL_X);
        check("video_on_fall_x", von_x, VON_FALL_X);
        check("line_wrap_y", 32'(y_d), 1);

        // Default mid-line reset at x=300.
        n = 0;
        while (x_d != 10'd300 && n < 4000) begin @(negedge clk); n++; end
        check("d_reach_x300", 32'(x_d), 300);
        rst_d = 1'b1;
        @(negedge clk);
        rst_d = 1'b0;
        check("d_mid_reset_x", 32'(x_d), 0);
        check("d_mid_reset_y", 32'(y_d), 0);

        // Small raster frame period between consecutive frame_ticks.
        n = 0;
        while (!frame_tick_s && n < 2 * S_FRAME) begin @(negedge clk); n++; end
        found = frame_tick_s;
        check("s_frame_tick_found", 32'(found), 1);
        n = 0;
        @(negedge clk);
        while (!frame_tick_s && n < 2 * S_FRAME) begin @(negedge clk); n++; end
        check("s_frame_period", n + 1, S_FRAME);

        // Reset landing on the frame_tick cycle: one clean frame follows.
        rst_s = 1'b1;
        @(negedge clk);
        rst_s = 1'b0;
        check("sim_reset_x", 32'(x_s), 0);
        check("sim_reset_y", 32'(y_s), 0);
        n = 0; ft_cnt = 0;
        while (n < S_FRAME - 1) begin
            if (frame_tick_s) ft_cnt++;
            @(negedge clk);
            n++;
        end
        check("sim_no_early_frame_tick", ft_cnt, 0);
        check("sim_frame_tick_at_end", 32'(frame_tick_s), 1);

        // Random mid-frame resets on the small raster.
        for (int i = 0; i < 15; i++) begin
            repeat ($urandom_range(1, 400)) @(negedge clk);
            rst_s = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            rst_s = 1'b0;
            check("rand_reset_x", 32'(x_s), 0);
        end
        repeat (S_FRAME + 50) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
